bank_wbuffer: RTL

Bank write buffer: the responder to the bank SRAM controller's write-data request port. It holds 128-bit store data posted by the crossbar in a small entry array, returns a buffer id per posted store, and on a controller request returns that entry's data exactly one cycle later, freeing the entry. It sits between the crossbar write path and the bank SRAM controller, alongside the issue unit that carries the id.

---
 rtl/bank_wbuffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/bank_wbuffer.sv
// Bank write buffer: holds store data posted by the crossbar and returns it
// to the bank SRAM controller one cycle after a read-and-free request.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low reset
//   xbar_wbuf_valid_i/ready_o     store handshake; data in xbar_wbuf_data_i
//   wbuf_xbar_id_o                entry index allocated on the handshake
//   sc_wbuf_req_valid_i/_id_i     controller read-and-free request
//   sc_wbuf_rtn_valid_o/_data_o   registered return pulse and data
//   wbuf_free_cnt_o               number of free entries
//   wbuf_err_o                    sticky illegal-request flag
module bank_wbuffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IW    = 8,
    parameter int unsigned DW    = 128
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          xbar_wbuf_valid_i,
    output logic                          xbar_wbuf_ready_o,
    input  logic [DW-1:0]                 xbar_wbuf_data_i,
    output logic [IW-1:0]                 wbuf_xbar_id_o,
    input  logic                          sc_wbuf_req_valid_i,
    input  logic [IW-1:0]                 sc_wbuf_req_wbuffer_id_i,
    output logic                          sc_wbuf_rtn_valid_o,
    output logic [DW-1:0]                 sc_wbuf_rtn_data_o,
    output logic [$clog2(DEPTH):0]        wbuf_free_cnt_o,
    output logic                          wbuf_err_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0] r_valid;
    logic [DW-1:0]    r_data [DEPTH];
    logic             r_rtn_valid;
    logic [DW-1:0]    r_rtn_data;
    logic [CW-1:0]    r_free_cnt;
    logic             r_err;

    logic [AW-1:0]    w_free_idx;
    logic             w_any_free;
    logic             w_alloc;
    logic [AW-1:0]    w_req_idx;
    logic             w_id_in_range;
    logic             w_req_legal;

    // Lowest-index free entry; scanning downward lets the lowest index win.
    always_comb begin
        w_free_idx = '0;
        w_any_free = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = AW'(i);
                w_any_free = 1'b1;
            end
        end
    end

    // Request decode: upper id bits must be zero and the entry must be live.
    always_comb begin
        w_req_idx     = sc_wbuf_req_wbuffer_id_i[AW-1:0];
        w_id_in_range = ((sc_wbuf_req_wbuffer_id_i >> AW) == IW'(0));
        w_req_legal   = sc_wbuf_req_valid_i && w_id_in_range && r_valid[w_req_idx];
    end

    // Ready is forced low during reset so no store is accepted then.
    assign xbar_wbuf_ready_o = rst_i && w_any_free;
    assign wbuf_xbar_id_o    = IW'(w_free_idx);
    assign w_alloc           = xbar_wbuf_valid_i && xbar_wbuf_ready_o;

    // Entry array; data words are not reset since valid bits gate every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_valid <= '0;
        end else begin
            // Alloc and legal free never target the same entry (free vs valid).
            if (w_alloc) begin
                r_valid[w_free_idx] <= 1'b1;
                r_data[w_free_idx]  <= xbar_wbuf_data_i;
            end
            if (w_req_legal) begin
                r_valid[w_req_idx] <= 1'b0;
            end
        end
    end

    // Return path, free counter and sticky error.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rtn_valid <= 1'b0;
            r_rtn_data  <= '0;
            r_free_cnt  <= CW'(DEPTH);
            r_err       <= 1'b0;
        end else begin
            // Illegal requests still pulse so the controller never stalls.
            r_rtn_valid <= sc_wbuf_req_valid_i;
            if (w_req_legal) begin
                r_rtn_data <= r_data[w_req_idx];
            end else if (sc_wbuf_req_valid_i) begin
                r_rtn_data <= '0;
                r_err      <= 1'b1;
            end
            if (w_req_legal && !w_alloc) begin
                r_free_cnt <= r_free_cnt + CW'(1);
            end else if (w_alloc && !w_req_legal) begin
                r_free_cnt <= r_free_cnt - CW'(1);
            end
        end
    end

    assign sc_wbuf_rtn_valid_o = r_rtn_valid;
    assign sc_wbuf_rtn_data_o  = r_rtn_data;
    assign wbuf_free_cnt_o     = r_free_cnt;
    assign wbuf_err_o          = r_err;

endmodule
